// File: rtl/register_pipe.sv
// register_pipe: Depth-stage valid/data register pipeline with stall and clear; REGISTER_PIPE_OCC_EN adds an occ counter
module register_pipe #(
  parameter int DataWidth = 32,
  parameter int Depth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 clr,
  input  logic                 wen,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata,
  output logic                 rdy,
  output logic                 busy
`ifdef REGISTER_PIPE_OCC_EN
  ,
  output logic [$clog2(Depth+1)-1:0] occ
`endif
);
  logic [Depth-1:0][DataWidth-1:0] d;
  logic [Depth-1:0]                v;
  logic [Depth:0]                  sh;
  logic [Depth:0][DataWidth-1:0]   src;
  // stage k loads from src[k] when sh[k] (its upstream valid) is set
  assign sh  = {v, wen};
  assign src = {d, wdata};
  always_ff @(posedge clk or posedge rst)
    if (rst) v <= '0;
    else if (clr) v <= '0;
    else if (!stall) v <= sh[Depth-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) d <= '0;
    else if (!clr && !stall)
      for (int k = 0; k < Depth; k++)
        if (sh[k]) d[k] <= src[k];
  assign rdata = d[Depth-1];
  assign rdy   = v[Depth-1];
  assign busy  = |v;
`ifdef REGISTER_PIPE_OCC_EN
  localparam int OW = $clog2(Depth + 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) occ <= '0;
    else if (clr) occ <= '0;
    else if (!stall) occ <= occ + OW'(wen) - OW'(v[Depth-1]);
`endif
endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: directed and randomized checks of register_pipe against an item/age queue model
module tb_register_pipe;
  localparam int DW = 8;
  localparam int DEPTH = 3;
  logic clk = 0, rst = 1, stall = 0, clr = 0, wen = 0;
  logic [DW-1:0] wdata = '0, rdata;
  logic rdy, busy;
  int n_cmp = 0, n_bad = 0;
`ifdef REGISTER_PIPE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  register_pipe #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .clr(clr), .wen(wen), .wdata(wdata),
    .rdata(rdata), .rdy(rdy), .busy(busy)
`ifdef REGISTER_PIPE_OCC_EN
    , .occ(occ)
`endif
  );

  always #5 clk = ~clk;

  // each in-flight item carries its age in edges; it is at the output when age == DEPTH-1
  typedef struct { logic [DW-1:0] d; int a; } item_t;
  item_t q[$];
  logic [DW-1:0] mlast = '0;

  function automatic void model_reset();
    q.delete();
    mlast = '0;
  endfunction

  function automatic void model_edge(input logic w, input logic [DW-1:0] wd, input logic s, input logic c);
    item_t it;
    if (c) q.delete();
    else if (!s) begin
      foreach (q[i]) q[i].a++;
      while (q.size() > 0 && q[0].a >= DEPTH) void'(q.pop_front());
      if (w) begin
        it.d = wd;
        it.a = 0;
        q.push_back(it);
      end
      foreach (q[i]) if (q[i].a == DEPTH - 1) mlast = q[i].d;
    end
  endfunction

  function automatic logic m_rdy();
    return q.size() > 0 && q[0].a == DEPTH - 1;
  endfunction

  function automatic logic m_busy();
    return q.size() > 0;
  endfunction

  task automatic step(input logic w, input logic [DW-1:0] wd, input logic s, input logic c);
    wen = w; wdata = wd; stall = s; clr = c;
    @(posedge clk);
    model_edge(w, wd, s, c);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 8'hFF, 0, 0);
    rst = 1;
    model_reset();
    #2;
    n_cmp++;
    if ({rdy, busy, rdata} !== {1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset: rdy=%b busy=%b rdata=%h want 0 0 00", rdy, busy, rdata);
    end
`ifdef REGISTER_PIPE_OCC_EN
    n_cmp++;
    if (occ !== 0) begin n_bad++; $display("FAIL reset_occ: occ=%0d want 0", occ); end
`endif
    rst = 0;
  endtask

  task automatic test_latency();
    bit er[4] = '{0, 0, 1, 0};
    int eo[4] = '{1, 1, 1, 0};
    step(1, 8'hA5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(0, 8'h00, 0, 0);
      n_cmp++;
      if (rdy !== er[i] || (er[i] && rdata !== 8'hA5)) begin
        n_bad++;
        $display("FAIL latency edge %0d: rdy=%b rdata=%h want rdy=%b", i + 1, rdy, rdata, er[i]);
      end
`ifdef REGISTER_PIPE_OCC_EN
      n_cmp++;
      if (occ !== eo[i]) begin n_bad++; $display("FAIL latency_occ edge %0d: occ=%0d want %0d", i + 1, occ, eo[i]); end
`endif
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] wd[8] = '{8'h11, 8'h22, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    bit w[8] = '{1, 1, 0, 1, 0, 0, 0, 0};
    bit er[8] = '{0, 0, 1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step(w[i], wd[i], 0, 0);
      n_cmp++;
      if (rdy !== er[i] || {rdy, busy, rdata} !== {m_rdy(), m_busy(), mlast}) begin
        n_bad++;
        $display("FAIL stream edge %0d: rdy=%b busy=%b rdata=%h want %b %b %h", i + 1, rdy, busy, rdata, er[i], m_busy(), mlast);
      end
    end
  endtask

  task automatic test_stall();
    bit s[6] = '{0, 0, 1, 1, 0, 0};
    bit w[6] = '{1, 0, 1, 1, 0, 0};
    logic [DW-1:0] wd[6] = '{8'h44, 8'h00, 8'h55, 8'h55, 8'h00, 8'h00};
    bit er[6] = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      step(w[i], wd[i], s[i], 0);
      n_cmp++;
      if (rdy !== er[i] || (er[i] && rdata !== 8'h44) || rdata === 8'h55 ||
          {rdy, busy, rdata} !== {m_rdy(), m_busy(), mlast}) begin
        n_bad++;
        $display("FAIL stall edge %0d: rdy=%b busy=%b rdata=%h want %b %b %h", i + 1, rdy, busy, rdata, er[i], m_busy(), mlast);
      end
    end
  endtask

  task automatic test_clr();
    logic [DW-1:0] keep;
    step(1, 8'h66, 0, 0);
    step(1, 8'h77, 0, 0);
    keep = mlast;
    step(1, 8'h88, 1, 1);
    n_cmp++;
    if ({rdy, busy, rdata} !== {1'b0, 1'b0, keep}) begin
      n_bad++;
      $display("FAIL clr: rdy=%b busy=%b rdata=%h want 0 0 %h", rdy, busy, rdata, keep);
    end
`ifdef REGISTER_PIPE_OCC_EN
    n_cmp++;
    if (occ !== 0) begin n_bad++; $display("FAIL clr_occ: occ=%0d want 0", occ); end
`endif
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 0, 0);
      n_cmp++;
      if (rdy !== 1'b0 || rdata !== keep) begin
        n_bad++;
        $display("FAIL clr_after edge %0d: rdy=%b rdata=%h want 0 %h", i + 1, rdy, rdata, keep);
      end
    end
  endtask

  task automatic test_midreset();
    step(1, 8'hC1, 0, 0);
    step(1, 8'hC2, 0, 0);
    step(1, 8'hC3, 0, 0);
    #1 rst = 1;
    model_reset();
    #1;
    n_cmp++;
    if ({rdy, busy, rdata} !== {1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL midreset: rdy=%b busy=%b rdata=%h want 0 0 00", rdy, busy, rdata);
    end
    #1 rst = 0;
    step(1, 8'h9A, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(0, 8'h00, 0, 0);
      n_cmp++;
      if (rdy !== (i == 2) || (i == 2 && rdata !== 8'h9A)) begin
        n_bad++;
        $display("FAIL midreset_refill edge %0d: rdy=%b rdata=%h want %b 9a", i + 1, rdy, rdata, i == 2);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      n_cmp++;
      if ({rdy, busy, rdata} !== {m_rdy(), m_busy(), mlast}) begin
        n_bad++;
        $display("FAIL random cyc %0d: rdy=%b busy=%b rdata=%h want %b %b %h", i, rdy, busy, rdata, m_rdy(), m_busy(), mlast);
      end
`ifdef REGISTER_PIPE_OCC_EN
      n_cmp++;
      if (occ !== q.size()) begin n_bad++; $display("FAIL random_occ cyc %0d: occ=%0d want %0d", i, occ, q.size()); end
`endif
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    test_reset();
    test_latency();
    test_stream();
    test_stall();
    test_clr();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/register_pipe.md
REGISTER_PIPE -- requirements
Module: register_pipe

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning the width of each stage's data.
REQ-002 SHALL have parameter Depth, default 4, meaning the number of register stages; legal range is 1..64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port stall, input, 1 bit: when 1, all stages hold.
REQ-006 SHALL have port clr, input, 1 bit: flushes all valid bits.
REQ-007 SHALL have port wen, input, 1 bit: marks wdata as valid for entry into stage 0.
REQ-008 SHALL have port wdata, input, DataWidth bits: write data.
REQ-009 SHALL have port rdata, output, DataWidth bits: data of the last stage (Depth-1).
REQ-010 SHALL have port rdy, output, 1 bit: valid bit of the last stage.
REQ-011 SHALL have port busy, output, 1 bit: OR of all stage valid bits.
REQ-012 SHALL have port occ, output, clog2(Depth+1) bits: number of valid stages; present only per REQ-027.

Function
REQ-013 Each stage k SHALL hold a data register d[k] and a valid bit v[k].
REQ-014 When stall=0 and clr=0, each rising edge SHALL update the stages as follows:
- v[0] <= wen, and d[0] <= wdata only if wen=1;
- for k>=1, v[k] <= v[k-1], and d[k] <= d[k-1] only if v[k-1]=1.
REQ-015 A data register whose load condition is false SHALL hold its value (no load of invalid data).
REQ-016 When stall=1 and clr=0, all d[] and v[] SHALL hold, and wen/wdata SHALL be ignored (the write is dropped).
REQ-017 When clr=1, each rising edge SHALL set all v[] to 0 and leave all d[] unchanged.
REQ-018 clr SHALL take priority over both stall and wen; an item written in the clr cycle is discarded.
REQ-019 Latency: wen=1 at edge t with no stall or clr in edges t..t+Depth-1 SHALL give rdy=1 and rdata=that wdata after edge t+Depth-1, i.e. visible during cycle t+Depth.
REQ-020 Back-to-back writes SHALL be accepted every unstalled cycle, giving throughput of 1 item per cycle.
REQ-021 Bubbles (wen=0) SHALL propagate as invalid stages; there is no collapse, so inter-item spacing is preserved.
REQ-022 rdata and rdy SHALL be driven directly from d[Depth-1] and v[Depth-1], with no combinational path from inputs.
REQ-023 busy SHALL be the combinational OR of v[0..Depth-1].
REQ-024 With Depth=1, stage 0 is the output stage; behaviour SHALL still follow REQ-014 to REQ-018.

Reset
REQ-025 While rst=1, all d[] SHALL be 0 and all v[] SHALL be 0, asynchronously, regardless of clk, stall, clr or wen.
REQ-026 Reset values of outputs SHALL be rdata=0, rdy=0, busy=0 and occ=0; rst asserted mid-stream SHALL discard all items, and the first edge after deassertion SHALL behave per REQ-014.

Configuration
REQ-027 Macro REGISTER_PIPE_OCC_EN SHALL control the occupancy counter:
- defined: port occ and a registered counter SHALL exist, always equal to the popcount of v[] in the same cycle, and updated on the same edge as v[] (+1 on valid entry, -1 on valid exit out of the last stage, 0 on clr, held on stall);
- undefined: the occ port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL use DataWidth=8 and Depth=3 and SHALL cover the following directed scenarios:
- Reset: rst pulse with no clk edge -> rdata=0x00, rdy=0, busy=0, occ=0.
- Latency: wen=1, wdata=0xA5 at edge 1, then wen=0 -> rdy=1 and rdata=0xA5 only in the cycle after edge 3; rdy=0 after edge 4; occ sequence 1,2,3,2 is wrong, the required sequence is 1,1,1,0.
- Streaming with bubble: wdata 0x11, 0x22 (wen=1), one idle cycle, then 0x33 -> rdy pattern 1,1,0,1 starting after edge 3, carrying 0x11, 0x22, -, 0x33.
- Stall: 0x44 in stage 1, stall=1 for 2 edges with wen=1, wdata=0x55 -> state frozen and 0x55 dropped; 0x44 exits 2 cycles later than unstalled.
- Clear priority: pipe holding 0x66 and 0x77, clr=1 together with stall=1 and wen=1 (wdata=0x88) -> after that edge rdy=0, busy=0 and occ=0, rdata keeps its last value, and 0x88 never appears.
- Mid-stream reset: rst asserted between edges with 3 items in flight -> immediate rdy=0 and rdata=0x00; a new write after release emerges after 3 edges.
